pipelined_control_unit: RTL and testbench

//  Registered successor of the combinational decoder.

---
 rtl/pipelined_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered RV32I/RV32F decoder that loads the ID/EX control register,
// honours hazard-unit stall/flush, and holds EX for multi-cycle FDIV.S/FSQRT.S via a small FSM.
module pipelined_control_unit #(
  parameter bit FP_EN        = 1'b1,
  parameter int FDIV_CYCLES  = 12,
  parameter int FSQRT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] instr,
  input  logic        stall_in,
  input  logic        flush,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [6:0]  ex_control,
  output logic [1:0]  mem_control,
  output logic [1:0]  wb_control,
  output logic [1:0]  jump,
  output logic [3:0]  fp_control,
  output logic        fpu_busy,
  output logic        unrecognized
);

  localparam int MAX_CYCLES = (FDIV_CYCLES > FSQRT_CYCLES) ? FDIV_CYCLES : FSQRT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] FDIV_LOAD  = CNT_W'(FDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] FSQRT_LOAD = CNT_W'(FSQRT_CYCLES - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOADFP = 7'b0000111;
  localparam logic [6:0] OP_STOREFP= 7'b0100111;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;

  localparam logic [1:0] SRC1_PC = 2'b00, SRC1_ZERO = 2'b01, SRC1_RS1 = 2'b10;
  localparam logic [1:0] SRC2_RS2 = 2'b00, SRC2_IMM = 2'b01, SRC2_FOUR = 2'b10;
  localparam logic [1:0] ALU_LDST = 2'b00, ALU_BRCH = 2'b01, ALU_ARITH = 2'b10, ALU_IMM = 2'b11;

  typedef enum logic {IDLE, MULTI} state_t;

  typedef struct packed {
    logic [6:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
    logic [1:0] jmp;
    logic [3:0] fp;
  } ctrl_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, dec_cnt;
  ctrl_t            ctrl_q, ctrl_n, dec;
  logic             ex_valid_n, unrec_n, dec_legal, dec_multi;

  logic [6:0] opcode, funct7;
  logic       unused_instr;
  assign opcode       = instr[6:0];
  assign funct7       = instr[31:25];
  assign unused_instr = ^instr[24:7];

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    dec_multi = 1'b0;
    dec_cnt   = '0;
    case (opcode)
      OP_R:      begin dec.ex = {SRC1_RS1, SRC2_RS2, ALU_ARITH, 1'b0}; dec.wb = 2'b01; end
      OP_I:      begin dec.ex = {SRC1_RS1, SRC2_IMM, ALU_IMM, 1'b0};   dec.wb = 2'b01; end
      OP_LOAD:   begin dec.ex = {SRC1_RS1, SRC2_IMM, ALU_LDST, 1'b0};  dec.mem = 2'b10; dec.wb = 2'b11; end
      OP_STORE:  begin dec.ex = {SRC1_RS1, SRC2_IMM, ALU_LDST, 1'b0};  dec.mem = 2'b01; end
      OP_BRANCH: dec.ex = {SRC1_RS1, SRC2_RS2, ALU_BRCH, 1'b1};
      OP_JAL:    begin dec.ex = {SRC1_PC, SRC2_FOUR, ALU_LDST, 1'b0};  dec.wb = 2'b01; dec.jmp = 2'b10; end
      OP_JALR:   begin dec.ex = {SRC1_RS1, SRC2_FOUR, ALU_LDST, 1'b0}; dec.wb = 2'b01; dec.jmp = 2'b01; end
      OP_LUI:    begin dec.ex = {SRC1_ZERO, SRC2_IMM, ALU_LDST, 1'b0}; dec.wb = 2'b01; end
      OP_AUIPC:  begin dec.ex = {SRC1_PC, SRC2_IMM, ALU_LDST, 1'b0};   dec.wb = 2'b01; end
      OP_LOADFP: begin
        dec.ex = {SRC1_RS1, SRC2_IMM, ALU_LDST, 1'b0};
        dec.mem = 2'b10; dec.wb = 2'b10; dec.fp = 4'b1100;
        dec_legal = FP_EN;
      end
      OP_STOREFP: begin
        dec.ex = {SRC1_RS1, SRC2_IMM, ALU_LDST, 1'b0};
        dec.mem = 2'b01; dec.fp = 4'b0001;
        dec_legal = FP_EN;
      end
      OP_FP: begin
        dec.ex = {SRC1_RS1, SRC2_RS2, ALU_ARITH, 1'b0};
        dec_legal = FP_EN;
        // FMV.X.W/FCLASS, FCMP and FCVT.W produce an integer result.
        if (funct7[6:2] inside {5'b11100, 5'b10100, 5'b11000}) begin
          dec.fp = 4'b1010; dec.wb = 2'b01;
        end else begin
          dec.fp = 4'b1100;
        end
        if (funct7 == 7'b0001100) begin dec_multi = 1'b1; dec_cnt = FDIV_LOAD;  end
        if (funct7 == 7'b0101100) begin dec_multi = 1'b1; dec_cnt = FSQRT_LOAD; end
      end
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        dec.ex = {SRC1_RS1, SRC2_RS2, ALU_ARITH, 1'b0};
        dec.fp = 4'b1100;
        dec_legal = FP_EN;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ctrl_n     = ctrl_q;
    ex_valid_n = ex_valid;
    unrec_n    = unrecognized;
    if (flush) begin
      state_n    = IDLE;
      cnt_n      = '0;
      ctrl_n     = '0;
      ex_valid_n = 1'b0;
      unrec_n    = 1'b0;
    end else begin
      // The counter runs even under stall and saturates at zero.
      if (cnt != '0) cnt_n = cnt - CNT_W'(1);
      // Leaving MULTI once the count is exhausted holds EX for exactly *_CYCLES cycles.
      if (state == MULTI && cnt == '0) state_n = IDLE;
      if (!stall_in) begin
        ctrl_n     = '0;
        ex_valid_n = 1'b0;
        unrec_n    = 1'b0;
        if (state == MULTI) begin
          if (cnt != '0) begin
            ctrl_n     = ctrl_q;
            ex_valid_n = ex_valid;
            unrec_n    = unrecognized;
          end
        end else if (id_valid) begin
          if (dec_legal) begin
            ctrl_n     = dec;
            ex_valid_n = 1'b1;
            if (dec_multi) begin
              state_n = MULTI;
              cnt_n   = dec_cnt;
            end
          end else begin
            unrec_n = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ctrl_q       <= '0;
      ex_valid     <= 1'b0;
      unrecognized <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ctrl_q       <= ctrl_n;
      ex_valid     <= ex_valid_n;
      unrecognized <= unrec_n;
    end
  end

  assign ex_control  = ctrl_q.ex;
  assign mem_control = ctrl_q.mem;
  assign wb_control  = ctrl_q.wb;
  assign jump        = ctrl_q.jmp;
  assign fp_control  = ctrl_q.fp;
  assign fpu_busy    = (state == MULTI);
  assign id_ready    = rst_n && (state == IDLE) && !stall_in;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: two instances (FP_EN=1 and FP_EN=0) share random and directed stimulus and are
// compared every cycle against a cycle-level reference model of the decode/stall/flush/busy rules.
module tb_pipelined_control_unit;

  localparam int FDIV_N  = 12;
  localparam int FSQRT_N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;

  logic       rdy_a, exv_a, busy_a, unr_a, rdy_b, exv_b, busy_b, unr_b;
  logic [6:0] exc_a, exc_b;
  logic [1:0] mem_a, wb_a, jmp_a, mem_b, wb_b, jmp_b;
  logic [3:0] fp_a, fp_b;

  pipelined_control_unit #(.FP_EN(1'b1), .FDIV_CYCLES(FDIV_N), .FSQRT_CYCLES(FSQRT_N)) u_fp (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr(instr), .stall_in(stall_in), .flush(flush),
    .id_ready(rdy_a), .ex_valid(exv_a), .ex_control(exc_a), .mem_control(mem_a), .wb_control(wb_a),
    .jump(jmp_a), .fp_control(fp_a), .fpu_busy(busy_a), .unrecognized(unr_a));

  pipelined_control_unit #(.FP_EN(1'b0), .FDIV_CYCLES(FDIV_N), .FSQRT_CYCLES(FSQRT_N)) u_nofp (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr(instr), .stall_in(stall_in), .flush(flush),
    .id_ready(rdy_b), .ex_valid(exv_b), .ex_control(exc_b), .mem_control(mem_b), .wb_control(wb_b),
    .jump(jmp_b), .fp_control(fp_b), .fpu_busy(busy_b), .unrecognized(unr_b));

  always #5 clk = ~clk;

  // {fpu_busy, ex_valid, unrecognized, ex_control, mem_control, wb_control, jump, fp_control}
  logic [19:0] act_a, act_b;
  assign act_a = {busy_a, exv_a, unr_a, exc_a, mem_a, wb_a, jmp_a, fp_a};
  assign act_b = {busy_b, exv_b, unr_b, exc_b, mem_b, wb_b, jmp_b, fp_b};

  typedef struct {
    bit          busy;
    int          occ;
    int          limit;
    logic [16:0] ctl;
    logic        exv;
    logic        unr;
  } model_t;

  typedef struct {
    logic        ready;
    logic [19:0] outs;
  } item_t;

  model_t m_a, m_b;
  item_t  q_a[$], q_b[$];
  int     checks = 0;
  int     failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Expected controls {ex7, mem2, wb2, jump2, fp4}, written out from the decode rules.
  function automatic void ref_decode(input logic [31:0] ins, input bit fp_en,
                                     output logic [16:0] v, output bit legal, output int limit);
    logic [6:0] f7;
    f7 = ins[31:25];
    v = '0; legal = 1'b1; limit = 0;
    case (ins[6:0])
      7'b0110011: v = {7'b1000100, 2'b00, 2'b01, 2'b00, 4'b0000};
      7'b0010011: v = {7'b1001110, 2'b00, 2'b01, 2'b00, 4'b0000};
      7'b0000011: v = {7'b1001000, 2'b10, 2'b11, 2'b00, 4'b0000};
      7'b0100011: v = {7'b1001000, 2'b01, 2'b00, 2'b00, 4'b0000};
      7'b1100011: v = {7'b1000011, 2'b00, 2'b00, 2'b00, 4'b0000};
      7'b1101111: v = {7'b0010000, 2'b00, 2'b01, 2'b10, 4'b0000};
      7'b0110111: v = {7'b0101000, 2'b00, 2'b01, 2'b00, 4'b0000};
      7'b0010111: v = {7'b0001000, 2'b00, 2'b01, 2'b00, 4'b0000};
      7'b1100111: v = {7'b1010000, 2'b00, 2'b01, 2'b01, 4'b0000};
      7'b0000111: begin legal = fp_en; v = {7'b1001000, 2'b10, 2'b10, 2'b00, 4'b1100}; end
      7'b0100111: begin legal = fp_en; v = {7'b1001000, 2'b01, 2'b00, 2'b00, 4'b0001}; end
      7'b1010011: begin
        legal = fp_en;
        if (f7[6:2] == 5'b11100 || f7[6:2] == 5'b10100 || f7[6:2] == 5'b11000)
          v = {7'b1000100, 2'b00, 2'b01, 2'b00, 4'b1010};
        else
          v = {7'b1000100, 2'b00, 2'b00, 2'b00, 4'b1100};
        if (f7 == 7'b0001100) limit = FDIV_N;
        if (f7 == 7'b0101100) limit = FSQRT_N;
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        legal = fp_en; v = {7'b1000100, 2'b00, 2'b00, 2'b00, 4'b1100};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) limit = 0;
  endfunction

  // One clock edge of the reference: occ counts EX cycles already spent by a multi-cycle op.
  function automatic model_t step(input model_t m, input logic v, input logic [31:0] ins,
                                  input logic st, input logic fl, input bit fp_en);
    model_t      n;
    logic [16:0] d;
    bit          legal;
    int          lim;
    n = m;
    if (fl) begin
      n = '{busy: 0, occ: 0, limit: 0, ctl: '0, exv: 0, unr: 0};
      return n;
    end
    if (m.busy) begin
      if (m.occ >= m.limit) begin
        n.busy = 0;
        if (!st) begin n.ctl = '0; n.exv = 0; n.unr = 0; end
      end else begin
        n.occ = m.occ + 1;
      end
      return n;
    end
    if (st) return n;
    n.ctl = '0; n.exv = 0; n.unr = 0;
    if (v) begin
      ref_decode(ins, fp_en, d, legal, lim);
      if (legal) begin
        n.ctl = d; n.exv = 1;
        if (lim > 0) begin n.busy = 1; n.occ = 1; n.limit = lim; end
      end else begin
        n.unr = 1;
      end
    end
    return n;
  endfunction

  function automatic logic [19:0] pack(input model_t m);
    return {m.busy, m.exv, m.unr, m.ctl};
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    item_t it;
    @(posedge clk);
    #2;
    id_valid = v; instr = ins; stall_in = st; flush = fl;
    it.ready = !m_a.busy && !st;
    m_a = step(m_a, v, ins, st, fl, 1'b1);
    it.outs = pack(m_a);
    q_a.push_back(it);
    it.ready = !m_b.busy && !st;
    m_b = step(m_b, v, ins, st, fl, 1'b0);
    it.outs = pack(m_b);
    q_b.push_back(it);
  endtask

  task automatic reset_models();
    m_a = '{busy: 0, occ: 0, limit: 0, ctl: '0, exv: 0, unr: 0};
    m_b = m_a;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs_fp"}, 32'(act_a), 32'd0);
    check({tag, "_outs_nofp"}, 32'(act_b), 32'd0);
    check({tag, "_ready_fp"}, 32'(rdy_a), 32'd0);
    check({tag, "_ready_nofp"}, 32'(rdy_b), 32'd0);
  endtask

  // Monitor: id_ready mid-cycle, registered outputs just after each edge.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) check("id_ready_fp", 32'(rdy_a), 32'(q_a[0].ready));
      if (q_b.size() > 0) check("id_ready_nofp", 32'(rdy_b), 32'(q_b[0].ready));
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin e = q_a.pop_front(); check("outs_fp", 32'(act_a), 32'(e.outs)); end
      if (q_b.size() > 0) begin e = q_b.pop_front(); check("outs_nofp", 32'(act_b), 32'(e.outs)); end
    end
  end

  localparam logic [31:0] R_ADD  = 32'h002081B3;
  localparam logic [31:0] LW     = 32'h00002083;
  localparam logic [31:0] FDIV   = {7'b0001100, 18'h0A5C3, 7'b1010011};
  localparam logic [31:0] FSQRT  = {7'b0101100, 18'h00000, 7'b1010011};

  logic [6:0] ops [16] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                           7'b0110111, 7'b0010111, 7'b1100111, 7'b0000111, 7'b0100111, 7'b1010011,
                           7'b1000011, 7'b1001111, 7'b1111111, 7'b1110011};
  logic [6:0] f7s [6] = '{7'b0001100, 7'b0101100, 7'b1110000, 7'b1010000, 7'b1100000, 7'b0000000};

  initial begin
    logic [31:0] r;
    reset_models();
    #3;
    check_reset_outputs("in_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, R_ADD, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, FDIV, 1'b0, 1'b0);
    for (int i = 0; i < FDIV_N + 2; i++) cycle(1'b1, R_ADD, 1'b0, 1'b0);

    cycle(1'b1, LW, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, R_ADD, 1'b1, 1'b0);
    cycle(1'b1, R_ADD, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, 32'h0000007F, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00002007, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, FSQRT, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, R_ADD, 1'b0, 1'b0);
    cycle(1'b1, R_ADD, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, FSQRT, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    reset_models();
    @(posedge clk);
    #2;
    id_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 700; i++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 3) == 0) r[31:25] = f7s[$urandom_range(0, 5)];
      cycle(($urandom_range(0, 9) < 8), r, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 4));
    end

    @(posedge clk);
    #3;
    check("queue_drained", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
